// File: rtl/write_back.sv
// write_back: final pipeline stage; drives the data-memory port, runs the
// multi-cycle load sequence and commits results to the register file.
// Ports: clk/reset (async active-low); execute-side inputs (comb_result_execute,
// dest_execute, flag_result_execute, addr_execute, data_out_execute,
// wen_execute, load_req, load_dest, halt); data memory (mem_addr,
// mem_data_out, mem_wen, mem_ren, mem_data_in); register file (rf_wen,
// rf_waddr, rf_wdata); forwarding (fwd_valid, fwd_dest, fwd_data);
// stall_wb back to upstream; retired_count.
// Optional feature macro: WB_RETIRE_CNT_EN enables the retired_count counter.
module write_back #(
  parameter int A_SIZE       = 10,
  parameter int D_SIZE       = 32,
  parameter int LOAD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [D_SIZE-1:0] comb_result_execute,
  input  logic [2:0]        dest_execute,
  input  logic              flag_result_execute,
  input  logic [A_SIZE-1:0] addr_execute,
  input  logic [D_SIZE-1:0] data_out_execute,
  input  logic              wen_execute,
  input  logic              load_req,
  input  logic [2:0]        load_dest,
  input  logic              halt,
  input  logic [D_SIZE-1:0] mem_data_in,
  output logic [A_SIZE-1:0] mem_addr,
  output logic [D_SIZE-1:0] mem_data_out,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic              rf_wen,
  output logic [2:0]        rf_waddr,
  output logic [D_SIZE-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [2:0]        fwd_dest,
  output logic [D_SIZE-1:0] fwd_data,
  output logic              stall_wb,
  output logic [31:0]       retired_count
);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        ldst_q, ldst_d;
  logic [A_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [D_SIZE-1:0] mem_dout_q, mem_dout_d;
  logic              mem_wen_q, mem_wen_d;
  logic              mem_ren_q, mem_ren_d;
  logic              rf_wen_q, rf_wen_d;
  logic [2:0]        rf_waddr_q, rf_waddr_d;
  logic [D_SIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [2:0]        fwd_dest_q, fwd_dest_d;
  logic [D_SIZE-1:0] fwd_data_q, fwd_data_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ldst_d      = ldst_q;
    mem_addr_d  = mem_addr_q;
    mem_dout_d  = mem_dout_q;
    mem_wen_d   = 1'b0;
    mem_ren_d   = 1'b0;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    fwd_valid_d = fwd_valid_q;
    fwd_dest_d  = fwd_dest_q;
    fwd_data_d  = fwd_data_q;
    unique case (state_q)
      IDLE: begin
        // Priority: load > store > commit; losers are dropped.
        if (!halt) begin
          if (load_req) begin
            mem_addr_d = addr_execute;
            mem_ren_d  = 1'b1;
            ldst_d     = load_dest;
            cnt_d      = 4'(LOAD_LATENCY);
            state_d    = LOAD_WAIT;
          end else if (wen_execute) begin
            mem_addr_d = addr_execute;
            mem_dout_d = data_out_execute;
            mem_wen_d  = 1'b1;
          end else if (flag_result_execute) begin
            rf_wen_d    = 1'b1;
            rf_waddr_d  = dest_execute;
            rf_wdata_d  = comb_result_execute;
            fwd_valid_d = 1'b1;
            fwd_dest_d  = dest_execute;
            fwd_data_d  = comb_result_execute;
          end
        end
      end
      LOAD_WAIT: begin
        // Execute inputs and halt are ignored until the load lands.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rf_wen_d    = 1'b1;
          rf_waddr_d  = ldst_q;
          rf_wdata_d  = mem_data_in;
          fwd_valid_d = 1'b1;
          fwd_dest_d  = ldst_q;
          fwd_data_d  = mem_data_in;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ldst_q      <= '0;
      mem_addr_q  <= '0;
      mem_dout_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      fwd_valid_q <= 1'b0;
      fwd_dest_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ldst_q      <= ldst_d;
      mem_addr_q  <= mem_addr_d;
      mem_dout_q  <= mem_dout_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_dest_q  <= fwd_dest_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_dout_q;
  assign mem_wen      = mem_wen_q;
  assign mem_ren      = mem_ren_q;
  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign fwd_valid    = fwd_valid_q;
  assign fwd_dest     = fwd_dest_q;
  assign fwd_data     = fwd_data_q;
  assign stall_wb     = (state_q == LOAD_WAIT);

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] ret_q, ret_d;

  // Counted on the same edge the pulse is raised; halt already
  // blocks new pulses except a finishing load.
  always_comb begin
    ret_d = ret_q;
    if (rf_wen_d || mem_wen_d) ret_d = ret_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ret_q <= '0;
    else        ret_q <= ret_d;
  end

  assign retired_count = ret_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed table-driven bench for write_back
// plus hand sequences for loads, halt and mid-load reset.
module tb_write_back;

  logic        clk;
  logic        reset;
  logic [31:0] comb_result_execute;
  logic [2:0]  dest_execute;
  logic        flag_result_execute;
  logic [9:0]  addr_execute;
  logic [31:0] data_out_execute;
  logic        wen_execute;
  logic        load_req;
  logic [2:0]  load_dest;
  logic        halt;
  logic [31:0] mem_data_in;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data_out;
  logic        mem_wen;
  logic        mem_ren;
  logic        rf_wen;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [2:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        stall_wb;
  logic [31:0] retired_count;

  int errors = 0;
  int checks = 0;

`ifdef WB_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  write_back dut (
    .clk                 (clk),
    .reset               (reset),
    .comb_result_execute (comb_result_execute),
    .dest_execute        (dest_execute),
    .flag_result_execute (flag_result_execute),
    .addr_execute        (addr_execute),
    .data_out_execute    (data_out_execute),
    .wen_execute         (wen_execute),
    .load_req            (load_req),
    .load_dest           (load_dest),
    .halt                (halt),
    .mem_data_in         (mem_data_in),
    .mem_addr            (mem_addr),
    .mem_data_out        (mem_data_out),
    .mem_wen             (mem_wen),
    .mem_ren             (mem_ren),
    .rf_wen              (rf_wen),
    .rf_waddr            (rf_waddr),
    .rf_wdata            (rf_wdata),
    .fwd_valid           (fwd_valid),
    .fwd_dest            (fwd_dest),
    .fwd_data            (fwd_data),
    .stall_wb            (stall_wb),
    .retired_count       (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lr, we, fl, ht;
    logic [2:0]  dest;
    logic [31:0] comb;
    logic [9:0]  addr;
    logic [31:0] dout;
    logic        e_rf_wen;
    logic [2:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_mem_wen;
    logic [9:0]  e_maddr;
    logic [31:0] e_mdo;
    logic        e_fv;
    logic [2:0]  e_fd;
    logic [31:0] e_fdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic lr, we, fl, ht,
                       input logic [2:0] dest, input logic [31:0] comb,
                       input logic [9:0] addr, input logic [31:0] dout,
                       input logic [2:0] ldst);
    load_req            = lr;
    wen_execute         = we;
    flag_result_execute = fl;
    halt                = ht;
    dest_execute        = dest;
    comb_result_execute = comb;
    addr_execute        = addr;
    data_out_execute    = dout;
    load_dest           = ldst;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 3'd0, 32'h0, 10'h0, 32'h0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, " mem_addr"}, 64'(mem_addr), 0);
    chk({n, " mem_data_out"}, 64'(mem_data_out), 0);
    chk({n, " mem_wen"}, 64'(mem_wen), 0);
    chk({n, " mem_ren"}, 64'(mem_ren), 0);
    chk({n, " rf_wen"}, 64'(rf_wen), 0);
    chk({n, " rf_waddr"}, 64'(rf_waddr), 0);
    chk({n, " rf_wdata"}, 64'(rf_wdata), 0);
    chk({n, " fwd_valid"}, 64'(fwd_valid), 0);
    chk({n, " fwd_dest"}, 64'(fwd_dest), 0);
    chk({n, " fwd_data"}, 64'(fwd_data), 0);
    chk({n, " stall_wb"}, 64'(stall_wb), 0);
    chk({n, " retired"}, 64'(retired_count), 0);
  endtask

  initial begin
    vecs[0] = '{0,0,1,0,3'd3,32'hA5,10'h0,32'h0,
                1,3'd3,32'hA5, 0,10'h0,32'h0, 1,3'd3,32'hA5};
    vecs[1] = '{0,0,1,0,3'd0,32'hFFFF_FFFF,10'h1,32'h1,
                1,3'd0,32'hFFFF_FFFF, 0,10'h0,32'h0,
                1,3'd0,32'hFFFF_FFFF};
    vecs[2] = '{0,0,0,0,3'd5,32'h5,10'h5,32'h5,
                0,3'd0,32'hFFFF_FFFF, 0,10'h0,32'h0,
                1,3'd0,32'hFFFF_FFFF};
    vecs[3] = '{0,1,0,0,3'd0,32'h0,10'h3FF,32'h1234_5678,
                0,3'd0,32'hFFFF_FFFF, 1,10'h3FF,32'h1234_5678,
                1,3'd0,32'hFFFF_FFFF};
    vecs[4] = '{0,0,0,0,3'd0,32'h0,10'h0,32'h0,
                0,3'd0,32'hFFFF_FFFF, 0,10'h3FF,32'h1234_5678,
                1,3'd0,32'hFFFF_FFFF};
    vecs[5] = '{0,1,1,0,3'd6,32'h77,10'h055,32'hCAFE,
                0,3'd0,32'hFFFF_FFFF, 1,10'h055,32'hCAFE,
                1,3'd0,32'hFFFF_FFFF};
    vecs[6] = '{1,1,1,1,3'd7,32'h99,10'h1AA,32'hBEEF,
                0,3'd0,32'hFFFF_FFFF, 0,10'h055,32'hCAFE,
                1,3'd0,32'hFFFF_FFFF};
    vecs[7] = '{0,0,1,0,3'd7,32'h99,10'h0,32'h0,
                1,3'd7,32'h99, 0,10'h055,32'hCAFE, 1,3'd7,32'h99};

    reset       = 1'b0;
    mem_data_in = 32'h0;
    idle_in();
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].lr, vecs[i].we, vecs[i].fl, vecs[i].ht,
            vecs[i].dest, vecs[i].comb, vecs[i].addr, vecs[i].dout, 3'd1);
      tick();
      chk($sformatf("v%0d rf_wen", i), 64'(rf_wen), 64'(vecs[i].e_rf_wen));
      chk($sformatf("v%0d rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].e_waddr));
      chk($sformatf("v%0d rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].e_wdata));
      chk($sformatf("v%0d mem_wen", i), 64'(mem_wen), 64'(vecs[i].e_mem_wen));
      chk($sformatf("v%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_maddr));
      chk($sformatf("v%0d mem_data_out", i), 64'(mem_data_out),
          64'(vecs[i].e_mdo));
      chk($sformatf("v%0d fwd_valid", i), 64'(fwd_valid), 64'(vecs[i].e_fv));
      chk($sformatf("v%0d fwd_dest", i), 64'(fwd_dest), 64'(vecs[i].e_fd));
      chk($sformatf("v%0d fwd_data", i), 64'(fwd_data), 64'(vecs[i].e_fdata));
      chk($sformatf("v%0d mem_ren", i), 64'(mem_ren), 0);
      chk($sformatf("v%0d stall_wb", i), 64'(stall_wb), 0);
    end
    // 3 commits + 2 stores in the table
    chk("table retired", 64'(retired_count), CNT_EN ? 64'd5 : 64'd0);

    // Load with a simultaneous commit request (dest 2) that must be dropped
    @(negedge clk);
    drive(1, 0, 1, 0, 3'd2, 32'h22, 10'h12, 32'h0, 3'd5);
    tick();
    chk("ld1 mem_ren", 64'(mem_ren), 1);
    chk("ld1 mem_addr", 64'(mem_addr), 64'h12);
    chk("ld1 stall", 64'(stall_wb), 1);
    chk("ld1 rf_wen", 64'(rf_wen), 0);
    @(negedge clk);
    drive(0, 1, 1, 0, 3'd4, 32'h44, 10'h3, 32'h3, 3'd6);
    mem_data_in = 32'hDEAD_BEEF;
    tick();
    chk("ld2 mem_ren", 64'(mem_ren), 0);
    chk("ld2 stall", 64'(stall_wb), 1);
    chk("ld2 rf_wen", 64'(rf_wen), 0);
    chk("ld2 mem_wen", 64'(mem_wen), 0);
    tick();
    chk("ld3 rf_wen", 64'(rf_wen), 1);
    chk("ld3 rf_waddr", 64'(rf_waddr), 5);
    chk("ld3 rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("ld3 stall", 64'(stall_wb), 0);
    chk("ld3 fwd_dest", 64'(fwd_dest), 5);
    chk("ld3 fwd_data", 64'(fwd_data), 64'hDEAD_BEEF);
    @(negedge clk);
    idle_in();
    tick();
    chk("ld4 rf_wen", 64'(rf_wen), 0);
    chk("ld4 rf_waddr", 64'(rf_waddr), 5);

    // Halt raised mid-load: load completes, then nothing accepted
    @(negedge clk);
    drive(1, 0, 0, 0, 3'd0, 32'h0, 10'h20, 32'h0, 3'd1);
    tick();
    @(negedge clk);
    drive(0, 0, 1, 1, 3'd3, 32'h33, 10'h0, 32'h0, 3'd0);
    mem_data_in = 32'h0BAD_F00D;
    tick();
    tick();
    chk("hl rf_wen", 64'(rf_wen), 1);
    chk("hl rf_waddr", 64'(rf_waddr), 1);
    chk("hl rf_wdata", 64'(rf_wdata), 64'h0BAD_F00D);
    tick();
    chk("hl idle rf_wen", 64'(rf_wen), 0);
    chk("hl idle stall", 64'(stall_wb), 0);
    chk("hl fwd_dest", 64'(fwd_dest), 1);

    // Reset during LOAD_WAIT abandons the load
    @(negedge clk);
    drive(1, 0, 0, 0, 3'd0, 32'h0, 10'h2A, 32'h0, 3'd6);
    mem_data_in = 32'h5555_AAAA;
    tick();
    chk("rl stall", 64'(stall_wb), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rl");
    @(negedge clk);
    idle_in();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rl post%0d rf_wen", i), 64'(rf_wen), 0);
      chk($sformatf("rl post%0d stall", i), 64'(stall_wb), 0);
    end
    chk("rl fwd_valid", 64'(fwd_valid), 0);

    // 3 commits + 1 store + 1 load
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 1, 0, 3'(i), 32'(i + 10), 10'h0, 32'h0, 3'd0);
      tick();
    end
    @(negedge clk);
    drive(0, 1, 0, 0, 3'd0, 32'h0, 10'h7, 32'h7, 3'd0);
    tick();
    @(negedge clk);
    drive(1, 0, 0, 0, 3'd0, 32'h0, 10'h8, 32'h0, 3'd7);
    tick();
    @(negedge clk);
    idle_in();
    tick();
    tick();
    chk("cnt ld rf_waddr", 64'(rf_waddr), 7);
    tick();
    chk("cnt retired", 64'(retired_count), CNT_EN ? 64'd5 : 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
